// File: rtl/bra_his_upd.sv
// Write-side controller for the branch history table and its pattern history counters.
// Define BRA_GSHARE_EN to index the PHT with history XOR branch address (gshare).
module bra_his_upd #(
    parameter int ADDR_W     = 8,
    parameter int HIST_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic              res_taken,
    input  logic              lkp_req,
    input  logic [ADDR_W-1:0] lkp_addr,
    output logic [ADDR_W-1:0] bht_addr,
    output logic              bht_wr_en,
    output logic              bht_wr_data,
    input  logic [HIST_W-1:0] bht_rd_data,
    output logic [HIST_W-1:0] pht_addr,
    input  logic [1:0]        pht_rd_data,
    output logic              pht_wr_en,
    output logic [1:0]        pht_wr_data,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // state   | meaning
    // S_IDLE  | nothing in flight, waiting for a queued entry and a free BHT port
    // S_READ  | head entry: read history and PHT counter, capture both
    // S_WRITE | head entry: shift-write history, write saturated counter, pop
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]     fifo_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_taken;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic capture;

    logic [ADDR_W-1:0] head_addr;
    logic              head_taken;
    logic [HIST_W-1:0] hist_q;
    logic [1:0]        ctr_q;
    logic [HIST_W-1:0] gs_term;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic taken);
        if (taken) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign res_ready  = !full;
    assign push       = res_valid && !full;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_taken = fifo_taken[rd_ptr];
    assign busy       = !empty || (state != S_IDLE);

`ifdef BRA_GSHARE_EN
    // Zero-extend the address into the history width, or keep its low bits if wider.
    always_comb begin
        gs_term = '0;
        for (int i = 0; i < HIST_W && i < ADDR_W; i++) begin
            gs_term[i] = head_addr[i];
        end
    end
`else
    assign gs_term = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_taken <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_addr[wr_ptr]  <= res_addr;
                fifo_taken[wr_ptr] <= res_taken;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            hist_q <= '0;
            ctr_q  <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                hist_q <= bht_rd_data;
                ctr_q  <= pht_rd_data;
            end
        end
    end

    // Lookups own the BHT port whenever they ask; the update engine simply stalls in place.
    always_comb begin
        state_nxt   = state;
        bht_addr    = lkp_req ? lkp_addr : head_addr;
        bht_wr_en   = 1'b0;
        bht_wr_data = 1'b0;
        pht_addr    = '0;
        pht_wr_en   = 1'b0;
        pht_wr_data = 2'b00;
        capture     = 1'b0;
        pop         = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !lkp_req) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (!lkp_req) begin
                    pht_addr  = bht_rd_data ^ gs_term;
                    capture   = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!lkp_req) begin
                    bht_wr_en   = 1'b1;
                    bht_wr_data = head_taken;
                    pht_addr    = hist_q ^ gs_term;
                    pht_wr_en   = 1'b1;
                    pht_wr_data = sat(ctr_q, head_taken);
                    pop         = 1'b1;
                    // A push landing on this same edge still counts as a remaining entry.
                    state_nxt   = ((count > CNT_W'(1)) || push) ? S_READ : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bra_his_upd.sv
// Self-checking bench for bra_his_upd: BHT/PHT memories are modelled here, and a
// high-level in-order reference computes every expected history shift and counter write.
`timescale 1ns/1ps
module tb_bra_his_upd;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       res_valid = 1'b0;
    logic       res_ready;
    logic [7:0] res_addr = 8'h00;
    logic       res_taken = 1'b0;
    logic       lkp_req = 1'b0;
    logic [7:0] lkp_addr = 8'h00;
    logic [7:0] bht_addr;
    logic       bht_wr_en;
    logic       bht_wr_data;
    logic [9:0] bht_rd_data;
    logic [9:0] pht_addr;
    logic [1:0] pht_rd_data;
    logic       pht_wr_en;
    logic [1:0] pht_wr_data;
    logic       busy;

    bra_his_upd #(.ADDR_W(8), .HIST_W(10), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_taken(res_taken),
        .lkp_req(lkp_req), .lkp_addr(lkp_addr),
        .bht_addr(bht_addr), .bht_wr_en(bht_wr_en), .bht_wr_data(bht_wr_data), .bht_rd_data(bht_rd_data),
        .pht_addr(pht_addr), .pht_rd_data(pht_rd_data), .pht_wr_en(pht_wr_en), .pht_wr_data(pht_wr_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic       bit_in;
        logic [9:0] paddr;
        logic [1:0] pdata;
        logic       ben;
        logic       pen;
        logic       lkp;
    } wr_t;

    typedef struct packed {
        logic [7:0] addr;
        logic       taken;
    } ent_t;

`ifdef BRA_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic [9:0] bht_mem [256];
    logic [1:0] pht_mem [1024];
    logic [9:0] ref_bht [256];
    logic [1:0] ref_pht [1024];

    wr_t  obs_q[$];
    int   obs_cyc[$];
    ent_t pend_q[$];
    wr_t  exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    assign bht_rd_data = bht_mem[bht_addr];
    assign pht_rd_data = pht_mem[pht_addr];

    // Memory model plus passive recorder of accepted pushes and observed write strobes.
    always @(posedge clk) begin
        if (!reset) begin
            if (res_valid && res_ready) pend_q.push_back(ent_t'{res_addr, res_taken});
            if (bht_wr_en || pht_wr_en) begin
                obs_q.push_back(wr_t'{bht_addr, bht_wr_data, pht_addr, pht_wr_data, bht_wr_en, pht_wr_en, lkp_req});
                obs_cyc.push_back(cyc);
            end
            if (bht_wr_en) bht_mem[bht_addr] <= {bht_mem[bht_addr][8:0], bht_wr_data};
            if (pht_wr_en) pht_mem[pht_addr] <= pht_wr_data;
        end
        cyc <= cyc + 1;
    end

    function automatic logic [9:0] ref_idx(input logic [9:0] h, input logic [7:0] a);
        return h ^ (GS ? {2'b00, a} : 10'h000);
    endfunction

    // Reference: entries retire strictly in order, each one seeing all earlier updates.
    task automatic build_expected();
        while (pend_q.size() > 0) begin
            ent_t       e;
            logic [9:0] h;
            logic [9:0] i;
            int         n;
            e = pend_q.pop_front();
            h = ref_bht[e.addr];
            i = ref_idx(h, e.addr);
            n = int'(ref_pht[i]) + (e.taken ? 1 : -1);
            if (n > 3) n = 3;
            if (n < 0) n = 0;
            exp_q.push_back(wr_t'{e.addr, e.taken, i, 2'(n), 1'b1, 1'b1, 1'b0});
            ref_bht[e.addr] = {h[8:0], e.taken};
            ref_pht[i] = 2'(n);
        end
    endtask

    task automatic clear_queues();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [9:0] h, input logic [1:0] c);
        bht_mem[a] = h;
        ref_bht[a] = h;
        pht_mem[ref_idx(h, a)] = c;
        ref_pht[ref_idx(h, a)] = c;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; lkp_req = 1'b1; lkp_addr = 8'h3C; res_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        vectors++;
        if ({res_ready, busy, bht_wr_en, pht_wr_en} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_flags: got ready/busy/bwe/pwe=%b expected 1000", {res_ready, busy, bht_wr_en, pht_wr_en});
        end
        vectors++;
        if (bht_addr !== 8'h3C) begin
            miscompares++;
            $display("FAIL reset_lkp_addr: got %h expected 3c", bht_addr);
        end
        lkp_req = 1'b0;
        #1;
        vectors++;
        if ({bht_addr, pht_addr, bht_wr_data, pht_wr_data} !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got bht_addr=%h pht_addr=%h bwd=%b pwd=%b expected all 0",
                     bht_addr, pht_addr, bht_wr_data, pht_wr_data);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_taken();
        logic [9:0] exp_idx;
        exp_idx = GS ? (10'h155 ^ 10'h005) : 10'h155;
        poke(8'h05, 10'h155, 2'b01);
        tick();
        res_valid = 1'b1; res_addr = 8'h05; res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bht_wr_en !== 1'b0 || pht_wr_en !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_idle: got bwe=%b pwe=%b busy=%b expected 0 0 1", bht_wr_en, pht_wr_en, busy);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (bht_wr_en !== 1'b0 || pht_addr !== exp_idx) begin
            miscompares++;
            $display("FAIL single_read: got bwe=%b pht_addr=%h expected 0 %h", bht_wr_en, pht_addr, exp_idx);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({bht_wr_en, pht_wr_en, bht_wr_data} !== 3'b111 || bht_addr !== 8'h05 ||
            pht_addr !== exp_idx || pht_wr_data !== 2'b10) begin
            miscompares++;
            $display("FAIL single_write: got bwe=%b pwe=%b bwd=%b bht_addr=%h pht_addr=%h pwd=%b expected 1 1 1 05 %h 10",
                     bht_wr_en, pht_wr_en, bht_wr_data, bht_addr, pht_addr, pht_wr_data, exp_idx);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (bht_wr_en !== 1'b0 || pht_wr_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_after: got bwe=%b pwe=%b busy=%b expected 0 0 0", bht_wr_en, pht_wr_en, busy);
        end
        tick();
        build_expected();
        vectors++;
        if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            miscompares++;
            $display("FAIL single_score: got %0d writes, expected exactly 1 matching the model", obs_q.size());
        end
        clear_queues();
    endtask

    task automatic test_saturation();
        bit ok;
        poke(8'h10, 10'h2A3, 2'b11);
        poke(8'h11, 10'h14C, 2'b00);
        tick();
        res_valid = 1'b1; res_addr = 8'h10; res_taken = 1'b1;
        tick();
        res_addr = 8'h11; res_taken = 1'b0;
        tick();
        res_valid = 1'b0;
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL sat_drain: busy still 1 after cycle budget, expected 0");
        end
        build_expected();
        vectors++;
        if (obs_q.size() != 2) begin
            miscompares++;
            $display("FAIL sat_count: got %0d writes expected 2", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0].pdata !== 2'b11 || obs_q[1].pdata !== 2'b00) begin
                miscompares++;
                $display("FAIL sat_values: got %b %b expected 11 00", obs_q[0].pdata, obs_q[1].pdata);
            end
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL sat_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        clear_queues();
    endtask

    task automatic test_full_queue();
        bit ok;
        int t0;
        lkp_req = 1'b1; lkp_addr = 8'h3A;
        for (int i = 0; i < 4; i++) begin
            tick();
            res_valid = 1'b1; res_addr = 8'($urandom); res_taken = 1'($urandom);
        end
        tick();
        res_addr = 8'hEE; res_taken = 1'b1;
        @(negedge clk);
        vectors++;
        if (res_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready: got %b expected 0", res_ready);
        end
        tick(); tick();
        @(negedge clk);
        vectors++;
        if (res_ready !== 1'b0 || busy !== 1'b1 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_hold: got ready=%b busy=%b writes=%0d expected 0 1 0", res_ready, busy, obs_q.size());
        end
        tick();
        res_valid = 1'b0; lkp_req = 1'b0;
        t0 = cyc;
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL full_drain: busy still 1 after cycle budget, expected 0");
        end
        build_expected();
        vectors++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            miscompares++;
            $display("FAIL full_count: got %0d writes expected 4 (model %0d)", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i] || obs_cyc[i] != t0 + 2 + 2 * i) begin
                    miscompares++;
                    $display("FAIL full_write[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                             i, obs_q[i], obs_cyc[i], exp_q[i], t0 + 2 + 2 * i);
                end
            end
        end
        clear_queues();
    endtask

    task automatic test_lookup_stall();
        logic [9:0] h;
        h = ref_bht[8'h44];
        tick();
        res_valid = 1'b1; res_addr = 8'h44; res_taken = 1'b0;
        tick();
        res_valid = 1'b0;
        tick();
        tick();
        lkp_req = 1'b1; lkp_addr = 8'h3A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bht_addr !== 8'h3A || bht_wr_en !== 1'b0 || pht_wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got bht_addr=%h bwe=%b pwe=%b expected 3a 0 0", i, bht_addr, bht_wr_en, pht_wr_en);
            end
            tick();
        end
        lkp_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bht_wr_en, pht_wr_en, bht_wr_data} !== 3'b110 || bht_addr !== 8'h44 || pht_addr !== ref_idx(h, 8'h44)) begin
            miscompares++;
            $display("FAIL stall_release: got bwe=%b pwe=%b bwd=%b bht_addr=%h pht_addr=%h expected 1 1 0 44 %h",
                     bht_wr_en, pht_wr_en, bht_wr_data, bht_addr, pht_addr, ref_idx(h, 8'h44));
        end
        tick(); tick();
        build_expected();
        vectors++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            miscompares++;
            $display("FAIL stall_score: got %0d writes, expected 1 write %h", obs_q.size(), exp_q[0]);
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        bit ok;
        tick();
        res_valid = 1'b1; res_addr = 8'h21; res_taken = 1'b1;
        tick();
        res_taken = 1'b0;
        tick();
        res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_drain: busy still 1 after cycle budget, expected 0");
        end
        build_expected();
        vectors++;
        if (obs_q.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d writes expected 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i] || (i > 0 && obs_cyc[i] != obs_cyc[i-1] + 2)) begin
                    miscompares++;
                    $display("FAIL b2b_write[%0d]: got %h expected %h, spacing must be 2 cycles", i, obs_q[i], exp_q[i]);
                end
            end
        end
        clear_queues();
    endtask

    task automatic test_gshare();
        logic [9:0] want;
        want = GS ? 10'h0FF : 10'h0F0;
        poke(8'h0F, 10'h0F0, 2'b10);
        tick();
        res_valid = 1'b1; res_addr = 8'h0F; res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if (pht_addr !== want) begin
            miscompares++;
            $display("FAIL gshare_read_idx: got %h expected %h", pht_addr, want);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (pht_addr !== want || pht_wr_en !== 1'b1 || pht_wr_data !== 2'b11) begin
            miscompares++;
            $display("FAIL gshare_write_idx: got %h pwe=%b pwd=%b expected %h 1 11", pht_addr, pht_wr_en, pht_wr_data, want);
        end
        tick(); tick();
        build_expected();
        clear_queues();
    endtask

    task automatic test_random();
        bit ok;
        for (int c = 0; c < 600; c++) begin
            tick();
            res_valid = 1'($urandom);
            res_addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            res_taken = 1'($urandom);
            lkp_req   = ($urandom_range(0, 3) == 0);
            lkp_addr  = 8'($urandom);
        end
        tick();
        res_valid = 1'b0; lkp_req = 1'b0;
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rand_drain: busy still 1 after cycle budget, expected 0");
        end
        build_expected();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rand_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_reset_mid();
        tick();
        res_valid = 1'b1; res_addr = 8'h77; res_taken = 1'b1;
        tick();
        res_addr = 8'h78; res_taken = 1'b0;
        tick();
        res_valid = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({res_ready, busy, bht_wr_en, pht_wr_en} !== 4'b1000) begin
            miscompares++;
            $display("FAIL midreset_flags: got ready/busy/bwe/pwe=%b expected 1000", {res_ready, busy, bht_wr_en, pht_wr_en});
        end
        tick();
        reset = 1'b0;
        pend_q.delete();
        repeat (10) tick();
        vectors++;
        if (obs_q.size() != 0 || busy !== 1'b0 || bht_mem[8'h77] !== ref_bht[8'h77]) begin
            miscompares++;
            $display("FAIL midreset_discard: got writes=%0d busy=%b hist77=%h expected 0 0 %h",
                     obs_q.size(), busy, bht_mem[8'h77], ref_bht[8'h77]);
        end
        clear_queues();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            bht_mem[i] = 10'($urandom);
            ref_bht[i] = bht_mem[i];
        end
        for (int i = 0; i < 1024; i++) begin
            pht_mem[i] = 2'($urandom);
            ref_pht[i] = pht_mem[i];
        end
        test_reset();
        test_single_taken();
        test_saturation();
        test_full_queue();
        test_lookup_stall();
        test_back_to_back();
        test_gshare();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
